axi_mem_responder: RTL and testbench

- AXI4+ATOP subordinate that terminates the core's data/instruction NoC port in simulation and FPGA harnesses. It serves reads and writes to a single-port synchronous SRAM-style memory.
- It sits on the memory side of the core's AXI master (ID 4 b, addr 64 b, data 64 b). It backs the cached region (base 0x8000_0000, 1 GiB).
- Bursts are FIXED/INCR/WRAP, including 2-beat WRAP refills of 128-bit cache lines.
- Transactions are serialised: one AXI transaction is in service at a time.

---
 rtl/axi_mem_responder_pkg.sv | 61 ++++++
 rtl/axi_mem_responder_addr_gen.sv | 53 +++++
 rtl/axi_mem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_responder_pkg.sv
// Shared types for the AXI memory responder: channel
// bundles, burst/resp encodings and the FSM state enum.
package axi_mem_responder_pkg;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic [5:0]        atop;
   } aw_chan_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } w_chan_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
   } b_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } ar_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
   } r_chan_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDATA,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_ATOP_R
   } state_t;

endpackage

// File: rtl/axi_mem_responder_addr_gen.sv
// Burst next-address, memory word address and beat error.
// Ports: i_addr/len/size/burst in; o_next, o_maddr, o_err out.
module axi_burst_addr_gen
   import axi_mem_responder_pkg::*;
#(
   parameter int unsigned          AddrWidth    = ADDR_W,
   parameter int unsigned          DataWidth    = DATA_W,
   parameter logic [AddrWidth-1:0] MemBase      = 64'h8000_0000,
   parameter logic [AddrWidth-1:0] MemBytes     = 64'h4000_0000,
   parameter int unsigned          MemAddrWidth = 27
) (
   input  logic [AddrWidth-1:0]    i_addr,
   input  logic [7:0]              i_len,
   input  logic [2:0]              i_size,
   input  logic [1:0]              i_burst,
   output logic [AddrWidth-1:0]    o_next,
   output logic [MemAddrWidth-1:0] o_maddr,
   output logic                    o_err
);

   localparam int unsigned OffW = $clog2(DataWidth / 8);

   logic [AddrWidth-1:0] w_step;
   logic [AddrWidth-1:0] w_mask;
   logic [AddrWidth-1:0] w_off;
   logic                 w_wrap_bad;
   logic                 w_size_bad;
   logic                 w_range_bad;

   assign w_step = AddrWidth'(1) << i_size;
   // wrap container is (len+1) beats; mask selects the offset inside it
   assign w_mask = ((AddrWidth'(i_len) + AddrWidth'(1)) << i_size)
                   - AddrWidth'(1);
   assign w_off  = i_addr - MemBase;

   always_comb begin
      o_next = i_addr + w_step;
      case (i_burst)
         BURST_FIXED: o_next = i_addr;
         BURST_WRAP:  o_next = (i_addr & ~w_mask)
                             | ((i_addr + w_step) & w_mask);
         default:     o_next = i_addr + w_step;
      endcase
   end

   assign w_wrap_bad  = (i_burst == BURST_WRAP)
                     && !(i_len inside {8'd1, 8'd3, 8'd7, 8'd15});
   assign w_size_bad  = i_size > 3'(OffW);
   assign w_range_bad = (i_addr < MemBase) || (w_off >= MemBytes);
   assign o_err       = w_wrap_bad || w_size_bad || w_range_bad;
   assign o_maddr     = MemAddrWidth'(w_off >> OffW);

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4+ATOP subordinate serving one transaction at a time from a
// single-port SRAM. Ports: AW/W/B/AR/R channels, mem_* SRAM port.
module axi_mem_responder
   import axi_mem_responder_pkg::*;
#(
   parameter int unsigned    IdWidth      = ID_W,
   parameter int unsigned    AddrWidth    = ADDR_W,
   parameter int unsigned    DataWidth    = DATA_W,
   parameter logic [63:0]    MemBase      = 64'h8000_0000,
   parameter logic [63:0]    MemBytes     = 64'h4000_0000,
   parameter int unsigned    MemAddrWidth = 27
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  aw_chan_t                aw_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   input  w_chan_t                 w_i,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   output b_chan_t                 b_o,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   input  ar_chan_t                ar_i,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output r_chan_t                 r_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [MemAddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0]    mem_wdata_o,
   output logic [DataWidth/8-1:0]  mem_be_o,
   input  logic [DataWidth-1:0]    mem_rdata_i
);

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    r_rr_wr;
   logic [IdWidth-1:0]      r_id;
   logic [AddrWidth-1:0]    r_addr;
   logic [7:0]              r_len;
   logic [2:0]              r_size;
   logic [1:0]              r_burst;
   logic [5:0]              r_atop;
   logic [7:0]              r_cnt;
   logic                    r_err;
   logic [1:0]              r_bresp;
   logic                    r_rhold;
   logic [DataWidth-1:0]    r_rdata;

   logic                    w_aw_gnt;
   logic                    w_ar_gnt;
   logic [AddrWidth-1:0]    w_next;
   logic [MemAddrWidth-1:0] w_maddr;
   logic                    w_gerr;
   logic                    w_wbad;
   logic                    w_wbeat;
   logic                    w_unused;

   axi_burst_addr_gen #(
      .AddrWidth    (AddrWidth),
      .DataWidth    (DataWidth),
      .MemBase      (MemBase),
      .MemBytes     (MemBytes),
      .MemAddrWidth (MemAddrWidth)
   ) u_addr_gen (
      .i_addr  (r_addr),
      .i_len   (r_len),
      .i_size  (r_size),
      .i_burst (r_burst),
      .o_next  (w_next),
      .o_maddr (w_maddr),
      .o_err   (w_gerr)
   );

   assign w_unused = w_i.last;

   // readies are gated by reset so nothing handshakes while held
   assign w_aw_gnt = rst_ni && (r_state == S_IDLE) && aw_valid_i
                  && (!ar_valid_i || r_rr_wr);
   assign w_ar_gnt = rst_ni && (r_state == S_IDLE) && ar_valid_i
                  && !w_aw_gnt;
   assign w_wbad   = w_gerr || (r_atop != 6'd0);
   assign w_wbeat  = (r_state == S_WDATA) && w_valid_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      aw_ready_o   = w_aw_gnt;
      ar_ready_o   = w_ar_gnt;
      w_ready_o    = 1'b0;
      b_valid_o    = 1'b0;
      r_valid_o    = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_be_o     = '0;
      mem_addr_o   = w_maddr;
      mem_wdata_o  = w_i.data;
      b_o          = '0;
      b_o.id       = r_id;
      b_o.resp     = r_bresp;
      r_o          = '0;
      r_o.id       = r_id;
      unique case (r_state)
         S_IDLE: begin
            if (w_aw_gnt)      w_next_state = S_WDATA;
            else if (w_ar_gnt) w_next_state = S_RADDR;
         end
         S_WDATA: begin
            w_ready_o = 1'b1;
            if (w_valid_i) begin
               mem_req_o = !w_wbad;
               mem_we_o  = 1'b1;
               mem_be_o  = w_wbad ? '0 : w_i.strb;
               if (r_cnt == 8'd0) w_next_state = S_WRESP;
            end
         end
         S_WRESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i)
               w_next_state = r_atop[5] ? S_ATOP_R : S_IDLE;
         end
         S_RADDR: begin
            mem_req_o    = !w_gerr;
            w_next_state = S_RDATA;
         end
         S_RDATA: begin
            // first cycle forwards SRAM data; later cycles use the copy
            r_valid_o = 1'b1;
            r_o.data  = w_gerr  ? '0
                      : r_rhold ? r_rdata : mem_rdata_i;
            r_o.resp  = w_gerr ? RESP_SLVERR : RESP_OKAY;
            r_o.last  = (r_cnt == 8'd0);
            if (r_ready_i)
               w_next_state = (r_cnt == 8'd0) ? S_IDLE : S_RADDR;
         end
         S_ATOP_R: begin
            r_valid_o = 1'b1;
            r_o.resp  = RESP_SLVERR;
            r_o.last  = 1'b1;
            if (r_ready_i) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_wr <= 1'b1;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_atop  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_bresp <= '0;
         r_rhold <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_aw_gnt) begin
            r_id    <= aw_i.id;
            r_addr  <= aw_i.addr;
            r_len   <= aw_i.len;
            r_size  <= aw_i.size;
            r_burst <= aw_i.burst;
            r_atop  <= aw_i.atop;
            r_cnt   <= aw_i.len;
            r_err   <= 1'b0;
            if (ar_valid_i) r_rr_wr <= 1'b0;
         end else if (w_ar_gnt) begin
            r_id    <= ar_i.id;
            r_addr  <= ar_i.addr;
            r_len   <= ar_i.len;
            r_size  <= ar_i.size;
            r_burst <= ar_i.burst;
            r_atop  <= '0;
            r_cnt   <= ar_i.len;
            if (aw_valid_i) r_rr_wr <= 1'b1;
         end
         if (w_wbeat) begin
            r_addr <= w_next;
            r_cnt  <= r_cnt - 8'd1;
            r_err  <= r_err || w_wbad;
            if (r_cnt == 8'd0)
               r_bresp <= (r_err || w_wbad) ? RESP_SLVERR : RESP_OKAY;
         end
         if (r_state == S_RDATA) begin
            if (!r_rhold) begin
               r_rdata <= mem_rdata_i;
               r_rhold <= 1'b1;
            end
            if (r_ready_i) begin
               r_rhold <= 1'b0;
               if (r_cnt != 8'd0) begin
                  r_cnt  <= r_cnt - 8'd1;
                  r_addr <= w_next;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: directed AXI traffic,
// expected B/R/memory accesses queued and checked by a monitor.
module tb_axi_mem_responder;
   import axi_mem_responder_pkg::*;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        aw_valid_i, aw_ready_o;
   aw_chan_t    aw_i;
   logic        w_valid_i, w_ready_o;
   w_chan_t     w_i;
   logic        b_valid_o, b_ready_i;
   b_chan_t     b_o;
   logic        ar_valid_i, ar_ready_o;
   ar_chan_t    ar_i;
   logic        r_valid_o, r_ready_i;
   r_chan_t     r_o;
   logic        mem_req_o, mem_we_o;
   logic [26:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_be_o;
   logic [63:0] mem_rdata_i;

   axi_mem_responder dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_i(aw_i),
      .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_i(w_i),
      .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_o(b_o),
      .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_i(ar_i),
      .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_o(r_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [26:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } mexp_t;
   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;
   typedef struct {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;

   mexp_t exp_m[$];
   bexp_t exp_b[$];
   rexp_t exp_r[$];
   mexp_t me;
   bexp_t be_;
   rexp_t re;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
   localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
   localparam logic [63:0] DC = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] DX = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] DY = 64'hFEDC_BA98_7654_3210;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic note_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event without expectation or timeout", nm);
   endtask

   // simple SRAM: low 9 word-address bits select the row
   logic [63:0] mem [512];
   function automatic logic [63:0] merge(input logic [63:0] o,
      input logic [63:0] n, input logic [7:0] m);
      logic [63:0] t;
      t = o;
      for (int b = 0; b < 8; b++)
         if (m[b]) t[b*8 +: 8] = n[b*8 +: 8];
      return t;
   endfunction

   always @(posedge clk) begin
      if (mem_req_o) begin
         if (mem_we_o)
            mem[mem_addr_o[8:0]] <= merge(mem[mem_addr_o[8:0]],
                                          mem_wdata_o, mem_be_o);
         else
            mem_rdata_i <= mem[mem_addr_o[8:0]];
      end
   end

   // monitor: pops an expectation whenever the DUT presents one
   always @(negedge clk) begin
      if (rst_ni) begin
         if (mem_req_o) begin
            if (exp_m.size() == 0) note_fail("mem_unexpected");
            else begin
               me = exp_m.pop_front();
               chk("mem_we", 64'(mem_we_o), 64'(me.we));
               chk("mem_addr", 64'(mem_addr_o), 64'(me.addr));
               if (me.we) begin
                  chk("mem_wdata", mem_wdata_o, me.data);
                  chk("mem_be", 64'(mem_be_o), 64'(me.be));
               end
            end
         end
         if (b_valid_o && b_ready_i) begin
            if (exp_b.size() == 0) note_fail("b_unexpected");
            else begin
               be_ = exp_b.pop_front();
               chk("b_id", 64'(b_o.id), 64'(be_.id));
               chk("b_resp", 64'(b_o.resp), 64'(be_.resp));
            end
         end
         if (r_valid_o && !r_ready_i && exp_r.size() != 0) begin
            chk("r_hold_data", r_o.data, exp_r[0].data);
            chk("r_hold_id", 64'(r_o.id), 64'(exp_r[0].id));
         end
         if (r_valid_o && r_ready_i) begin
            if (exp_r.size() == 0) note_fail("r_unexpected");
            else begin
               re = exp_r.pop_front();
               chk("r_id", 64'(r_o.id), 64'(re.id));
               chk("r_data", r_o.data, re.data);
               chk("r_resp", 64'(r_o.resp), 64'(re.resp));
               chk("r_last", 64'(r_o.last), 64'(re.last));
            end
         end
      end
   end

   task automatic send_aw(input logic [3:0] id, input logic [63:0] a,
      input logic [7:0] len, input logic [1:0] bu, input logic [5:0] at);
      int k = 0;
      aw_i.id = id; aw_i.addr = a; aw_i.len = len;
      aw_i.size = 3'd3; aw_i.burst = bu; aw_i.atop = at;
      aw_valid_i = 1'b1;
      do begin @(negedge clk); k++; end
      while (!aw_ready_o && k < 100);
      if (!aw_ready_o) note_fail("aw_timeout");
      @(posedge clk); #1 aw_valid_i = 1'b0;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [63:0] a,
      input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
      int k = 0;
      ar_i.id = id; ar_i.addr = a; ar_i.len = len;
      ar_i.size = sz; ar_i.burst = bu;
      ar_valid_i = 1'b1;
      do begin @(negedge clk); k++; end
      while (!ar_ready_o && k < 100);
      if (!ar_ready_o) note_fail("ar_timeout");
      @(posedge clk); #1 ar_valid_i = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] d, input logic lst);
      int k = 0;
      w_i.data = d; w_i.strb = 8'hFF; w_i.last = lst;
      w_valid_i = 1'b1;
      do begin @(negedge clk); k++; end
      while (!w_ready_o && k < 100);
      if (!w_ready_o) note_fail("w_timeout");
      @(posedge clk); #1 w_valid_i = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_m.size() != 0 || exp_b.size() != 0
              || exp_r.size() != 0) && k < 300) begin
         @(posedge clk); k++;
      end
      if (k >= 300) note_fail("drain_timeout");
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pm(input logic we, input logic [26:0] a,
                     input logic [63:0] d);
      exp_m.push_back('{we, a, d, 8'hFF});
   endtask

   task automatic pr(input logic [3:0] id, input logic [63:0] d,
                     input logic [1:0] rs, input logic l);
      exp_r.push_back('{id, d, rs, l});
   endtask

   task automatic check_quiet(input string nm);
      chk({nm, "_aw_ready"}, 64'(aw_ready_o), 64'd0);
      chk({nm, "_ar_ready"}, 64'(ar_ready_o), 64'd0);
      chk({nm, "_w_ready"}, 64'(w_ready_o), 64'd0);
      chk({nm, "_b_valid"}, 64'(b_valid_o), 64'd0);
      chk({nm, "_r_valid"}, 64'(r_valid_o), 64'd0);
      chk({nm, "_mem_req"}, 64'(mem_req_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = '0;
      rst_ni = 1'b0;
      aw_valid_i = 1'b1; ar_valid_i = 1'b1; w_valid_i = 1'b1;
      aw_i = '0; ar_i = '0; w_i = '0;
      b_ready_i = 1'b1; r_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      chk("reset_b_o", 64'(b_o), 64'd0);
      chk("reset_r_data", r_o.data, 64'd0);
      aw_valid_i = 1'b0; ar_valid_i = 1'b0; w_valid_i = 1'b0;
      @(negedge clk) rst_ni = 1'b1;
      @(posedge clk); #1;

      // single write then read back
      pm(1, 27'h2, DC);
      exp_b.push_back('{4'd1, RESP_OKAY});
      fork
         send_aw(4'd1, 64'h8000_0010, 8'd0, BURST_INCR, 6'd0);
         send_w(DC, 1'b1);
      join
      drain();
      pm(0, 27'h2, 0);
      pr(4'd2, DC, RESP_OKAY, 1);
      send_ar(4'd2, 64'h8000_0010, 8'd0, 3'd3, BURST_INCR);
      drain();

      // fill words 0/1 then WRAP refill starting at word 1
      pm(1, 27'h0, DA); pm(1, 27'h1, DB);
      exp_b.push_back('{4'd3, RESP_OKAY});
      fork
         send_aw(4'd3, 64'h8000_0000, 8'd1, BURST_INCR, 6'd0);
         begin send_w(DA, 1'b0); send_w(DB, 1'b1); end
      join
      drain();
      pm(0, 27'h1, 0); pm(0, 27'h0, 0);
      pr(4'd5, DB, RESP_OKAY, 0);
      pr(4'd5, DA, RESP_OKAY, 1);
      send_ar(4'd5, 64'h8000_0008, 8'd1, 3'd3, BURST_WRAP);
      drain();

      // INCR len 3 read with beat 1 held off for 4 cycles
      pm(0, 27'h0, 0); pm(0, 27'h1, 0);
      pm(0, 27'h2, 0); pm(0, 27'h3, 0);
      pr(4'd4, DA, RESP_OKAY, 0);
      pr(4'd4, DB, RESP_OKAY, 0);
      pr(4'd4, DC, RESP_OKAY, 0);
      pr(4'd4, 64'd0, RESP_OKAY, 1);
      send_ar(4'd4, 64'h8000_0000, 8'd3, 3'd3, BURST_INCR);
      begin
         int k = 0;
         do begin @(negedge clk); k++; end
         while (!(r_valid_o && r_ready_i) && k < 50);
         if (k >= 50) note_fail("bp_beat0_timeout");
         @(posedge clk); #1 r_ready_i = 1'b0;
         repeat (5) @(posedge clk);
         #1 r_ready_i = 1'b1;
      end
      drain();

      // simultaneous AW/AR: write wins first, read wins next time
      pm(1, 27'h4, DX); pm(0, 27'h0, 0);
      exp_b.push_back('{4'd6, RESP_OKAY});
      pr(4'd7, DA, RESP_OKAY, 1);
      fork
         send_aw(4'd6, 64'h8000_0020, 8'd0, BURST_INCR, 6'd0);
         send_w(DX, 1'b1);
         send_ar(4'd7, 64'h8000_0000, 8'd0, 3'd3, BURST_INCR);
      join
      drain();
      pm(0, 27'h4, 0); pm(1, 27'h5, DY);
      pr(4'd9, DX, RESP_OKAY, 1);
      exp_b.push_back('{4'd8, RESP_OKAY});
      fork
         send_aw(4'd8, 64'h8000_0028, 8'd0, BURST_INCR, 6'd0);
         send_w(DY, 1'b1);
         send_ar(4'd9, 64'h8000_0020, 8'd0, 3'd3, BURST_INCR);
      join
      drain();

      // error responses
      pr(4'd10, 64'd0, RESP_SLVERR, 0);
      pr(4'd10, 64'd0, RESP_SLVERR, 1);
      send_ar(4'd10, 64'h4000_0000, 8'd1, 3'd3, BURST_INCR);
      drain();
      pr(4'd14, 64'd0, RESP_SLVERR, 1);
      send_ar(4'd14, 64'h8000_0000, 8'd0, 3'd4, BURST_INCR);
      drain();
      pr(4'd15, 64'd0, RESP_SLVERR, 0);
      pr(4'd15, 64'd0, RESP_SLVERR, 0);
      pr(4'd15, 64'd0, RESP_SLVERR, 1);
      send_ar(4'd15, 64'h8000_0000, 8'd2, 3'd3, BURST_WRAP);
      drain();
      pm(0, 27'h7FF_FFFF, 0);
      pr(4'd3, 64'd0, RESP_OKAY, 0);
      pr(4'd3, 64'd0, RESP_SLVERR, 1);
      send_ar(4'd3, 64'hBFFF_FFF8, 8'd1, 3'd3, BURST_INCR);
      drain();
      pm(1, 27'h7FF_FFFF, 64'h7777);
      exp_b.push_back('{4'd2, RESP_SLVERR});
      fork
         send_aw(4'd2, 64'hBFFF_FFF8, 8'd1, BURST_INCR, 6'd0);
         begin send_w(64'h7777, 1'b0); send_w(64'h8888, 1'b1); end
      join
      drain();
      exp_b.push_back('{4'd11, RESP_SLVERR});
      pr(4'd11, 64'd0, RESP_SLVERR, 1);
      fork
         send_aw(4'd11, 64'h8000_0030, 8'd0, BURST_INCR, 6'h20);
         send_w(64'h5A5A, 1'b1);
      join
      drain();

      // reset in the middle of an 8-beat write
      pm(1, 27'h20, 64'h100); pm(1, 27'h21, 64'h101);
      fork
         send_aw(4'd12, 64'h8000_0100, 8'd7, BURST_INCR, 6'd0);
         begin send_w(64'h100, 1'b0); send_w(64'h101, 1'b0); end
      join
      w_i.data = 64'h102; w_valid_i = 1'b1;
      aw_valid_i = 1'b1; ar_valid_i = 1'b1;
      #2 rst_ni = 1'b0;
      #1 check_quiet("midreset");
      w_valid_i = 1'b0; aw_valid_i = 1'b0; ar_valid_i = 1'b0;
      @(negedge clk) rst_ni = 1'b1;
      @(posedge clk); #1;
      pm(0, 27'h2, 0);
      pr(4'd13, DC, RESP_OKAY, 1);
      send_ar(4'd13, 64'h8000_0010, 8'd0, 3'd3, BURST_INCR);
      drain();

      chk("left_mem", 64'(exp_m.size()), 64'd0);
      chk("left_b", 64'(exp_b.size()), 64'd0);
      chk("left_r", 64'(exp_r.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
